odd_even_seq_checker: RTL



---
 rtl/odd_even_pkg.sv | 20 ++
 rtl/odd_even_err_counter.sv | 23 ++
 rtl/odd_even_seq_checker.sv | 116 +++++++++++
 3 files changed

// File: rtl/odd_even_pkg.sv
// Shared definitions for the odd/even number generator and checker pair.
package odd_even_pkg;

    // Run state shared by the generator and the checker.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } oe_state_t;

    localparam logic MODE_EVEN = 1'b1;
    localparam logic MODE_ODD  = 1'b0;

    // Next value of an odd or even sequence. Callers truncate the result to
    // their own data width, which gives the modulo-2^WIDTH wrap for free.
    function automatic logic [63:0] next_expected(input logic [63:0] cur);
        return cur + 64'd2;
    endfunction

endpackage

// File: rtl/odd_even_err_counter.sv
// Saturating error counter with synchronous clear.
module odd_even_err_counter #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count
);

    // Clear wins over increment; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CW{1'b1}})) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/odd_even_seq_checker.sv
// Consumer end of the odd/even generator stream: checks COUNT values against
// the expected odd or even sequence, classifies errors and reports a verdict.
//
// Handshake: a beat transfers on a rising clk edge where in_valid && in_ready.
// in_ready is high for the whole CHECK state and only then, so the checker
// never back-pressures a run in progress; upstream may drop in_valid at will.
module odd_even_seq_checker
    import odd_even_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  COUNT = 20,
    localparam int CW    = $clog2(COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_even,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CW-1:0]    parity_errs,
    output logic [CW-1:0]    seq_errs,
    output logic [CW-1:0]    first_err_idx,
    output logic             mismatch
);

    oe_state_t        state;
    logic             mode;
    logic [WIDTH-1:0] expected;
    logic [CW-1:0]    idx;

    logic start_ok;
    logic accept;
    logic parity_bad;
    logic seq_bad;
    logic beat_err;
    logic last_beat;

    assign in_ready   = (state == CHECK);
    assign busy       = (state == CHECK);
    assign accept     = in_valid && in_ready;
    assign start_ok   = start && (state != CHECK);
    // The LSB test runs first, so a value with the wrong parity is never also
    // counted as a sequence error.
    assign parity_bad = accept && (in_data[0] != ~mode);
    assign seq_bad    = accept && !parity_bad && (in_data != expected);
    assign beat_err   = parity_bad || seq_bad;
    assign last_beat  = accept && (idx == CW'(COUNT - 1));

    odd_even_err_counter #(.CW(CW)) u_parity_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .inc   (parity_bad),
        .count (parity_errs)
    );

    odd_even_err_counter #(.CW(CW)) u_seq_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .inc   (seq_bad),
        .count (seq_errs)
    );

    // Run FSM: latches the mode on start, tracks the expected value and beat
    // index, records the first error and produces the registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mode          <= MODE_ODD;
            expected      <= '0;
            idx           <= '0;
            pass          <= 1'b0;
            done          <= 1'b0;
            mismatch      <= 1'b0;
            first_err_idx <= CW'(COUNT);
        end else begin
            done     <= 1'b0;
            mismatch <= beat_err;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mode          <= is_even;
                        expected      <= (is_even == MODE_EVEN) ? '0 : WIDTH'(1);
                        idx           <= '0;
                        pass          <= 1'b0;
                        first_err_idx <= CW'(COUNT);
                        state         <= CHECK;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        // No resync: the expectation advances regardless of in_data.
                        expected <= WIDTH'(next_expected(64'(expected)));
                        idx      <= idx + CW'(1);
                        // first_err_idx still equal to COUNT means no error yet.
                        if (beat_err && (first_err_idx == CW'(COUNT))) begin
                            first_err_idx <= idx;
                        end
                        if (last_beat) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= (parity_errs == '0) && (seq_errs == '0) && !beat_err;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
